dec_func_unit: RTL and testbench
================================

Name: dec_func_unit

Overview:
Parametrised, registered N-to-2^N decoder driving a programmable sum-of-minterms function. A loadable minterm mask replaces the fixed OR of decoder outputs. A sweep mode walks all 2^N input codes and counts the true minterms, for self-check and truth-table readout. Sits in the lab datapath wherever a decoder-based Boolean function is needed.

Parameters:
N, 4, select width; decoder has 2^N outputs (2^N is a derived localparam, not overridable).
MASK_INIT, 16'hC2CA, reset value of the minterm mask, 2^N bits wide. Bit i set means minterm i is true. The default encodes minterms 1,3,6,7,9,14,15 for N=4.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous reset, active-low.
en  input  1  decoder enable. Low forces y=0 and f=0 and pauses a sweep.
w  input  N  input code for single evaluation.
in_valid  input  1  request single evaluation of w.
mask_load  input  1  load mask_in into the mask register.
mask_in  input  2^N  new minterm mask.
sweep_start  input  1  start a full sweep of all codes.
y  output  2^N  registered one-hot decode, LSB-indexed (bit k high means code k).
f  output  1  registered function value, mask[code].
f_valid  output  1  one-cycle pulse qualifying y and f.
sweep_busy  output  1  high while state is SWEEP.
sweep_done  output  1  high for exactly one cycle, while state is DONE.
ones_count  output  N+1  count of true minterms from the last sweep.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, mask=MASK_INIT, cnt=0, y=0, f=0, f_valid=0, ones_count=0. sweep_busy and sweep_done are 0.
- The FSM has three states: IDLE, SWEEP and DONE.
- f_valid defaults to 0 on every edge unless set by the rules below. y and f hold their values between pulses.
- IDLE, in_valid=1 with sweep_start=0: at the next edge, f_valid=1. If en=1, y=onehot(w) and f=mask[w]. If en=0, y=0 and f=0 (f_valid still pulses). Latency is 1 cycle. Back-to-back requests give back-to-back pulses.
- IDLE, mask_load=1: the mask takes mask_in at the edge. An evaluation on the same edge uses the old mask.
- mask_load is ignored in SWEEP and DONE.
- IDLE, sweep_start=1: takes priority over in_valid, and that in_valid is dropped. At the edge: state goes to SWEEP, cnt=0, ones_count=0. A mask_load on the same edge is accepted, so the sweep uses the new mask.
- SWEEP, en=1, at each edge:
  - y=onehot(cnt), f=mask[cnt], f_valid=1;
  - ones_count += mask[cnt];
  - cnt increments.
  - When cnt=2^N-1, state goes to DONE and cnt wraps to 0. There is no overflow, because ones_count is N+1 bits and its maximum is 2^N.
- SWEEP, en=0: cnt and ones_count hold, f_valid=0, y=0, f=0. The sweep resumes from the same cnt when en returns high.
- In SWEEP and DONE, in_valid and sweep_start are ignored.
- DONE: sweep_done=1 for one cycle. This cycle coincides with the f_valid for code 2^N-1, and ones_count is already final. The next edge returns to IDLE.
- With en held high, the sweep occupies 2^N edges after the start edge and returns to IDLE at edge 2^N+1.
- ones_count holds its value until the next sweep_start or reset.
- Reset asserted mid-sweep aborts the sweep immediately. All state returns to reset values, including mask=MASK_INIT. No sweep_done is produced.

Test Plan:
- Reset, N=4: hold rst_n=0 mid-cycle -> y=0, f=0, f_valid=0, ones_count=0, sweep_busy=0, sweep_done=0 without a clock edge.
- Default mask, en=1: in_valid with w=9 -> next cycle y=16'h0200, f=1, f_valid=1. Then w=2 -> y=16'h0004, f=0.
- en=0, in_valid with w=3 -> f_valid=1, y=0, f=0.
- mask_load with mask_in=16'h0001 on the same cycle as in_valid, w=0 -> f=0 (old mask). Then w=0 again -> f=1.
- Default mask, sweep_start with en=1:
  - 16 consecutive f_valid pulses, y walking 0x0001 to 0x8000;
  - f sequence matching 0xC2CA bit by bit;
  - sweep_done coincides with the 16th pulse and ones_count=7;
  - IDLE on the following edge.
- Sweep with mask=16'hFFFF and en dropped for 3 cycles at cnt=5 -> no pulses while en=0, cnt resumes at 5, ones_count=16. Then a second sweep with reset asserted at cnt=8 -> IDLE, mask=16'hC2CA, ones_count=0, no sweep_done.

Source files
------------

// File: rtl/dec_func_if.sv
`default_nettype none
// ============================================================================
//  Module   : dec_func_if
//  Purpose  : Bundles the request, mask-load, sweep-control and result
//             signals of the decoder-based function unit.
//  Revision : 1.0  initial release
// ============================================================================
interface dec_func_if #(
   parameter int N = 4
);
   localparam int c_num_codes = 2**N;

   // Request side
   logic                    en;
   logic [N-1:0]            w;
   logic                    in_valid;
   logic                    mask_load;
   logic [c_num_codes-1:0]  mask_in;
   logic                    sweep_start;

   // Result side
   logic [c_num_codes-1:0]  y;
   logic                    f;
   logic                    f_valid;
   logic                    sweep_busy;
   logic                    sweep_done;
   logic [N:0]              ones_count;

   modport master (
      output en, w, in_valid, mask_load, mask_in, sweep_start,
      input  y, f, f_valid, sweep_busy, sweep_done, ones_count
   );

   modport slave (
      input  en, w, in_valid, mask_load, mask_in, sweep_start,
      output y, f, f_valid, sweep_busy, sweep_done, ones_count
   );
endinterface
`default_nettype wire

// File: rtl/dec_func_unit.sv
`default_nettype none
// ============================================================================
//  Module   : dec_func_unit
//  Purpose  : Registered N-to-2^N decoder feeding a programmable
//             sum-of-minterms function, with a sweep mode that walks every
//             input code and counts the true minterms.
//  Revision : 1.0  initial release
// ============================================================================
module dec_func_unit #(
   parameter int                 N         = 4,
   parameter logic [(2**N)-1:0]  MASK_INIT = 16'hC2CA
) (
   input  logic       clk,
   input  logic       rst_n,
   dec_func_if.slave  bus
);

   localparam int                    c_num_codes   = 2**N;
   localparam logic [N-1:0]          c_last_code   = N'(c_num_codes - 1);
   localparam logic [N-1:0]          c_cnt_one     = N'(1);
   localparam logic [c_num_codes-1:0] c_onehot_base = c_num_codes'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SWEEP = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t                    r_state;
   logic [c_num_codes-1:0]    r_mask;
   logic [N-1:0]              r_cnt;
   logic [c_num_codes-1:0]    r_y;
   logic                      r_f;
   logic                      r_f_valid;
   logic [N:0]                r_ones_count;

   // Minterm lookups for the single-evaluation path and the sweep path
   logic                      w_eval_bit;
   logic                      w_sweep_bit;

   assign w_eval_bit  = r_mask[bus.w];
   assign w_sweep_bit = r_mask[r_cnt];

   // Controller: request handling, sweep walk and minterm counting
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_mask       <= MASK_INIT;
         r_cnt        <= '0;
         r_y          <= '0;
         r_f          <= 1'b0;
         r_f_valid    <= 1'b0;
         r_ones_count <= '0;
      end else begin
         // The qualifier is a single-cycle pulse; y and f hold between pulses
         r_f_valid <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               // Loading is independent of the other requests; an evaluation
               // on this edge still sees the previous mask.
               if (bus.mask_load) begin
                  r_mask <= bus.mask_in;
               end

               if (bus.sweep_start) begin
                  // A sweep request wins and swallows any simultaneous request
                  r_state      <= ST_SWEEP;
                  r_cnt        <= '0;
                  r_ones_count <= '0;
               end else if (bus.in_valid) begin
                  r_f_valid <= 1'b1;
                  if (bus.en) begin
                     r_y <= c_onehot_base << bus.w;
                     r_f <= w_eval_bit;
                  end else begin
                     r_y <= '0;
                     r_f <= 1'b0;
                  end
               end
            end

            ST_SWEEP: begin
               if (bus.en) begin
                  r_y          <= c_onehot_base << r_cnt;
                  r_f          <= w_sweep_bit;
                  r_f_valid    <= 1'b1;
                  r_ones_count <= r_ones_count + {{N{1'b0}}, w_sweep_bit};
                  if (r_cnt == c_last_code) begin
                     // Last code: counter wraps, count is final on this edge
                     r_state <= ST_DONE;
                     r_cnt   <= '0;
                  end else begin
                     r_cnt <= r_cnt + c_cnt_one;
                  end
               end else begin
                  // Paused: outputs forced low, position and count retained
                  r_y <= '0;
                  r_f <= 1'b0;
               end
            end

            ST_DONE: begin
               r_state <= ST_IDLE;
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.y          = r_y;
   assign bus.f          = r_f;
   assign bus.f_valid    = r_f_valid;
   assign bus.ones_count = r_ones_count;
   assign bus.sweep_busy = (r_state == ST_SWEEP);
   assign bus.sweep_done = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_dec_func_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dec_func_unit
//  Purpose  : Directed self-checking bench for dec_func_unit.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dec_func_unit;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   dec_func_if #(.N(4)) bus_if ();

   dec_func_unit #(
      .N         (4),
      .MASK_INIT (16'hC2CA)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if.slave)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case the sequence ever stalls
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [15:0] exp_mask;
      logic [15:0] exp_y;

      checks = 0;
      errors = 0;

      rst_n              = 1'b1;
      bus_if.en          = 1'b0;
      bus_if.w           = '0;
      bus_if.in_valid    = 1'b0;
      bus_if.mask_load   = 1'b0;
      bus_if.mask_in     = '0;
      bus_if.sweep_start = 1'b0;

      // Asynchronous reset before any clock edge
      #2 rst_n = 1'b0;
      #1;
      chk("rst_y",          32'(bus_if.y),          32'h0);
      chk("rst_f",          32'(bus_if.f),          32'h0);
      chk("rst_f_valid",    32'(bus_if.f_valid),    32'h0);
      chk("rst_ones_count", 32'(bus_if.ones_count), 32'h0);
      chk("rst_busy",       32'(bus_if.sweep_busy), 32'h0);
      chk("rst_done",       32'(bus_if.sweep_done), 32'h0);
      #9 rst_n = 1'b1;   // released at t=12, clear of the edges

      // Single evaluations with the default mask
      @(posedge clk); #1;
      bus_if.en = 1'b1; bus_if.in_valid = 1'b1; bus_if.w = 4'd9;
      tick();
      chk("eval9_y",  32'(bus_if.y),       32'h0200);
      chk("eval9_f",  32'(bus_if.f),       32'h1);
      chk("eval9_fv", 32'(bus_if.f_valid), 32'h1);
      bus_if.w = 4'd2;
      tick();
      chk("eval2_y",  32'(bus_if.y),       32'h0004);
      chk("eval2_f",  32'(bus_if.f),       32'h0);
      chk("eval2_fv", 32'(bus_if.f_valid), 32'h1);
      bus_if.in_valid = 1'b0;
      tick();
      chk("hold_fv", 32'(bus_if.f_valid), 32'h0);
      chk("hold_y",  32'(bus_if.y),       32'h0004);

      // Disabled decoder still pulses the qualifier
      bus_if.en = 1'b0; bus_if.in_valid = 1'b1; bus_if.w = 4'd3;
      tick();
      chk("dis_fv", 32'(bus_if.f_valid), 32'h1);
      chk("dis_y",  32'(bus_if.y),       32'h0);
      chk("dis_f",  32'(bus_if.f),       32'h0);
      bus_if.en = 1'b1;

      // Mask load coinciding with an evaluation uses the old mask
      bus_if.mask_load = 1'b1; bus_if.mask_in = 16'h0001; bus_if.w = 4'd0;
      tick();
      chk("ld_old_f",  32'(bus_if.f),       32'h0);
      chk("ld_old_y",  32'(bus_if.y),       32'h0001);
      chk("ld_old_fv", 32'(bus_if.f_valid), 32'h1);
      bus_if.mask_load = 1'b0;
      tick();
      chk("ld_new_f", 32'(bus_if.f), 32'h1);
      bus_if.in_valid = 1'b0;

      // Restore the default mask, then sweep; the simultaneous request is dropped
      bus_if.mask_load = 1'b1; bus_if.mask_in = 16'hC2CA;
      tick();
      bus_if.mask_load = 1'b0;
      bus_if.sweep_start = 1'b1; bus_if.in_valid = 1'b1; bus_if.w = 4'd5;
      tick();
      bus_if.sweep_start = 1'b0; bus_if.in_valid = 1'b0;
      chk("sw1_start_busy", 32'(bus_if.sweep_busy), 32'h1);
      chk("sw1_start_fv",   32'(bus_if.f_valid),    32'h0);
      chk("sw1_start_ones", 32'(bus_if.ones_count), 32'h0);
      exp_mask = 16'hC2CA;
      for (int k = 0; k < 16; k++) begin
         tick();
         exp_y = 16'h0001 << k;
         chk("sw1_fv",   32'(bus_if.f_valid),    32'h1);
         chk("sw1_y",    32'(bus_if.y),          32'(exp_y));
         chk("sw1_f",    32'(bus_if.f),          32'(exp_mask[k]));
         chk("sw1_done", 32'(bus_if.sweep_done), (k == 15) ? 32'h1 : 32'h0);
      end
      chk("sw1_ones", 32'(bus_if.ones_count), 32'd7);
      tick();
      chk("sw1_idle_busy", 32'(bus_if.sweep_busy), 32'h0);
      chk("sw1_idle_done", 32'(bus_if.sweep_done), 32'h0);
      chk("sw1_idle_fv",   32'(bus_if.f_valid),    32'h0);
      chk("sw1_ones_hold", 32'(bus_if.ones_count), 32'd7);
      bus_if.in_valid = 1'b1; bus_if.w = 4'd14;
      tick();
      bus_if.in_valid = 1'b0;
      chk("post_eval_y", 32'(bus_if.y), 32'h4000);
      chk("post_eval_f", 32'(bus_if.f), 32'h1);

      // All-ones mask, pause for three cycles at code 5; loads during sweep ignored
      bus_if.mask_load = 1'b1; bus_if.mask_in = 16'hFFFF;
      tick();
      bus_if.mask_load = 1'b0;
      bus_if.sweep_start = 1'b1;
      tick();
      bus_if.sweep_start = 1'b0;
      bus_if.mask_load = 1'b1; bus_if.mask_in = 16'h0000;
      for (int k = 0; k < 5; k++) begin
         tick();
         exp_y = 16'h0001 << k;
         chk("sw2a_y", 32'(bus_if.y), 32'(exp_y));
         chk("sw2a_f", 32'(bus_if.f), 32'h1);
      end
      bus_if.en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("sw2_pause_fv",   32'(bus_if.f_valid),    32'h0);
         chk("sw2_pause_y",    32'(bus_if.y),          32'h0);
         chk("sw2_pause_busy", 32'(bus_if.sweep_busy), 32'h1);
         chk("sw2_pause_ones", 32'(bus_if.ones_count), 32'd5);
      end
      bus_if.en = 1'b1;
      for (int k = 5; k < 16; k++) begin
         tick();
         exp_y = 16'h0001 << k;
         chk("sw2b_fv",   32'(bus_if.f_valid),    32'h1);
         chk("sw2b_y",    32'(bus_if.y),          32'(exp_y));
         chk("sw2b_f",    32'(bus_if.f),          32'h1);
         chk("sw2b_done", 32'(bus_if.sweep_done), (k == 15) ? 32'h1 : 32'h0);
      end
      chk("sw2_ones", 32'(bus_if.ones_count), 32'd16);
      bus_if.mask_load = 1'b0;
      tick();
      chk("sw2_idle_busy", 32'(bus_if.sweep_busy), 32'h0);

      // Third sweep aborted by reset at code 8
      bus_if.sweep_start = 1'b1;
      tick();
      bus_if.sweep_start = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
      end
      chk("sw3_pre_ones", 32'(bus_if.ones_count), 32'd8);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(bus_if.sweep_busy), 32'h0);
      chk("abort_done", 32'(bus_if.sweep_done), 32'h0);
      chk("abort_ones", 32'(bus_if.ones_count), 32'h0);
      chk("abort_y",    32'(bus_if.y),          32'h0);
      chk("abort_fv",   32'(bus_if.f_valid),    32'h0);
      #2 rst_n = 1'b1;
      tick();
      chk("abort_idle_done", 32'(bus_if.sweep_done), 32'h0);
      chk("abort_idle_busy", 32'(bus_if.sweep_busy), 32'h0);
      // Mask is back to its reset value: code 0 false, code 1 true
      bus_if.in_valid = 1'b1; bus_if.w = 4'd0;
      tick();
      chk("abort_mask0", 32'(bus_if.f), 32'h0);
      bus_if.w = 4'd1;
      tick();
      chk("abort_mask1", 32'(bus_if.f), 32'h1);
      bus_if.in_valid = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
